immed_sequencer: RTL and testbench
==================================

Name: immed_sequencer

Overview:
- Controls the ImmediateReader on behalf of InsnDecoder and captures up to two immediates per instruction into immed1/immed2.
- Owns the single byte-FIFO read port and grants it to either the decoder or the immediate reader.
- This replaces the free-running OR of the two fifo_rd_en sources with explicit ownership.
- Includes an optional wait-timeout watchdog for bring-up.

Parameters:
- WAIT_TIMEOUT, 0: cycles allowed in WAIT before error abort; 0 disables the watchdog.
- TIMEOUT_WIDTH, 8: width of the watchdog counter; WAIT_TIMEOUT must be less than 2**TIMEOUT_WIDTH.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; aborts any sequence
- req_valid  in  1  decoder requests immediate fetch
- req_ready  out  1  sequencer can accept a request
- req_count  in  2  number of immediates, 0..2; value 3 is treated as 2
- req_8bit  in  2  bit i set means immediate i is 8-bit
- done  out  1  one-cycle pulse; immed1/immed2 valid
- immed1  out  16  first captured immediate
- immed2  out  16  second captured immediate
- immed_start  out  1  ImmediateReader start pulse
- immed_is_8bit  out  1  ImmediateReader width select
- immed_complete  in  1  ImmediateReader completion
- immediate  in  16  ImmediateReader result, already extended
- dec_fifo_rd_en  in  1  decoder FIFO read request
- ir_fifo_rd_en  in  1  ImmediateReader FIFO read request
- fifo_rd_en  out  1  FIFO read strobe to the byte FIFO
- fifo_owner  out  1  0 = decoder owns the port, 1 = ImmediateReader owns it
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE, idx=0, immed1=immed2=0, done=0, immed_start=0, immed_is_8bit=0, fifo_owner=0, timeout_err=0, counter=0.
- States: IDLE, START, WAIT, DONE.
- req_ready = (state==IDLE) & ~flush.
- A request is accepted on req_valid & req_ready. On accept: latch count and 8-bit flags, clear immed1/immed2, set idx=0.
- Accept with count==0: go to DONE.
- Accept with count!=0: go to START.
- START (one cycle):
  - immed_start=1 and immed_is_8bit=req_8bit_latched[idx].
  - Next state is WAIT.
  - immed_complete is ignored in START.
- WAIT:
  - immed_is_8bit is held.
  - On immed_complete, write immediate into slot idx (0 → immed1, 1 → immed2).
  - If idx+1 < count: idx++ and go to START. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. immed1/immed2 hold their values until the next accept.
- Latency, count=1: accept at cycle N, start at N+1. If complete arrives at cycle M, done is at M+1.
- Back-to-back: a request may be accepted the cycle after DONE.
- FIFO port:
  - fifo_owner = (state==START | state==WAIT).
  - fifo_rd_en = fifo_owner ? ir_fifo_rd_en : dec_fifo_rd_en. The non-owner's request is dropped, not queued.
- flush:
  - Takes priority over all other events, including immed_complete in the same cycle.
  - Next state is IDLE, idx=0, no done.
  - Captured immediates are cleared to 0.
  - timeout_err is unaffected.
- Watchdog (WAIT_TIMEOUT != 0):
  - Counter clears on entry to WAIT and increments each WAIT cycle without complete.
  - Reaching WAIT_TIMEOUT sets timeout_err, goes to IDLE with no done, and clears immediates.
  - timeout_err clears only on reset.
- Reset mid-sequence has the same effect as reset from IDLE. Reset wins over flush.

Decomposition:
- Shared package holds:
  - the state enum type (IDLE/START/WAIT/DONE);
  - the constant MAX_IMMEDIATES=2;
  - the 2-bit immediate-index typedef.
- Sub-module immed_wait_watchdog: parameterised counter with clear/enable inputs and an expired output. It is tied off when WAIT_TIMEOUT==0.
- Everything else stays in a single module.

Test Plan:
1. count=0 request → done pulse 1 cycle after accept; immed1=immed2=0; no immed_start; fifo_owner stays 0.
2. count=1, 8bit=1, reader returns 0xFFF0 → one immed_start with immed_is_8bit=1; immed1=0xFFF0; done one cycle after complete; immed2=0.
3. count=2, 8bit=2'b01, reader returns 0x0012 then 0xBEEF:
   - first start has is_8bit=1, second has is_8bit=0;
   - immed1=0x0012, immed2=0xBEEF; exactly two starts and one done.
4. FIFO arbitration: during WAIT, dec_fifo_rd_en=1 and ir_fifo_rd_en=0 → fifo_rd_en=0. In IDLE, dec_fifo_rd_en=1 → fifo_rd_en=1.
5. flush in the same cycle as immed_complete during the first of two immediates → no done; IDLE next cycle; immed1=0; req_ready=1 the following cycle.
6. WAIT_TIMEOUT=4 with complete never asserted → timeout_err=1 after 4 WAIT cycles and state returns to IDLE. A later request still completes normally while timeout_err stays 1.

Source files
------------

// File: rtl/immed_sequencer_pkg.sv
// Shared types for the immediate sequencer.
// State encoding, slot count and index type.
package immed_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } seq_state_t;

  localparam int MAX_IMMEDIATES = 2;

  typedef logic [1:0] imm_idx_t;

  // A count of 3 is treated as the maximum of 2.
  function automatic imm_idx_t clamp_count(input logic [1:0] c);
    return (c > 2'(MAX_IMMEDIATES)) ? 2'(MAX_IMMEDIATES) : c;
  endfunction

endpackage

// File: rtl/immed_wait_watchdog.sv
// WAIT-state cycle counter for the immediate sequencer.
// Flags expiry on the LIMIT-th enabled cycle after a clear.
module immed_wait_watchdog #(
  parameter int unsigned LIMIT = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/immed_sequencer.sv
// Drives the ImmediateReader for the decoder and
// owns the byte-FIFO read port while it runs.
module immed_sequencer
  import immed_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT  = 0,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_count,
  input  logic [1:0]  req_8bit,
  output logic        done,
  output logic [15:0] immed1,
  output logic [15:0] immed2,
  output logic        immed_start,
  output logic        immed_is_8bit,
  input  logic        immed_complete,
  input  logic [15:0] immediate,
  input  logic        dec_fifo_rd_en,
  input  logic        ir_fifo_rd_en,
  output logic        fifo_rd_en,
  output logic        fifo_owner,
  output logic        timeout_err
);

  seq_state_t state;
  imm_idx_t   idx;
  imm_idx_t   idx_nxt;
  imm_idx_t   cnt_q;
  imm_idx_t   req_cnt;
  logic [1:0] flags_q;
  logic       wd_expired;

  assign req_ready  = (state == S_IDLE) && !flush;
  assign fifo_owner = (state == S_START) || (state == S_WAIT);
  assign fifo_rd_en = fifo_owner ? ir_fifo_rd_en : dec_fifo_rd_en;
  assign idx_nxt    = idx + 2'd1;
  assign req_cnt    = clamp_count(req_count);

  generate
    if (WAIT_TIMEOUT != 0) begin : g_wd
      immed_wait_watchdog #(
        .LIMIT (WAIT_TIMEOUT),
        .WIDTH (TIMEOUT_WIDTH)
      ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_START),
        .enable  ((state == S_WAIT) && !immed_complete),
        .expired (wd_expired)
      );
    end else begin : g_no_wd
      assign wd_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt_q         <= '0;
      flags_q       <= '0;
      immed1        <= '0;
      immed2        <= '0;
      done          <= 1'b0;
      immed_start   <= 1'b0;
      immed_is_8bit <= 1'b0;
      timeout_err   <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      idx         <= '0;
      immed1      <= '0;
      immed2      <= '0;
      done        <= 1'b0;
      immed_start <= 1'b0;
    end else begin
      done        <= 1'b0;
      immed_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cnt_q   <= req_cnt;
            flags_q <= req_8bit;
            idx     <= '0;
            immed1  <= '0;
            immed2  <= '0;
            if (req_cnt == 2'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state         <= S_START;
              immed_start   <= 1'b1;
              immed_is_8bit <= req_8bit[0];
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (immed_complete) begin
            if (idx[0]) immed2 <= immediate;
            else        immed1 <= immediate;
            if (idx_nxt < cnt_q) begin
              idx           <= idx_nxt;
              state         <= S_START;
              immed_start   <= 1'b1;
              immed_is_8bit <= flags_q[idx_nxt[0]];
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            idx         <= '0;
            immed1      <= '0;
            immed2      <= '0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_immed_sequencer.sv
// Directed bench for immed_sequencer: default build
// plus a second instance with a 4-cycle watchdog.
module tb_immed_sequencer;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid;
  logic [1:0]  req_count, req_8bit;
  logic        immed_complete;
  logic [15:0] immediate;
  logic        dec_fifo_rd_en, ir_fifo_rd_en;

  logic        req_ready, done, immed_start, immed_is_8bit;
  logic [15:0] immed1, immed2;
  logic        fifo_rd_en, fifo_owner, timeout_err;

  logic        w_req_ready, w_done, w_immed_start, w_immed_is_8bit;
  logic [15:0] w_immed1, w_immed2;
  logic        w_fifo_rd_en, w_fifo_owner, w_timeout_err;

  int n_checks = 0;
  int n_fails  = 0;
  int n_starts = 0;
  int n_dones  = 0;

  always #5 clk = ~clk;

  immed_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_count(req_count), .req_8bit(req_8bit),
    .done(done), .immed1(immed1), .immed2(immed2),
    .immed_start(immed_start), .immed_is_8bit(immed_is_8bit),
    .immed_complete(immed_complete), .immediate(immediate),
    .dec_fifo_rd_en(dec_fifo_rd_en), .ir_fifo_rd_en(ir_fifo_rd_en),
    .fifo_rd_en(fifo_rd_en), .fifo_owner(fifo_owner),
    .timeout_err(timeout_err)
  );

  immed_sequencer #(.WAIT_TIMEOUT(4), .TIMEOUT_WIDTH(8)) dut_wd (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(w_req_ready),
    .req_count(req_count), .req_8bit(req_8bit),
    .done(w_done), .immed1(w_immed1), .immed2(w_immed2),
    .immed_start(w_immed_start), .immed_is_8bit(w_immed_is_8bit),
    .immed_complete(immed_complete), .immediate(immediate),
    .dec_fifo_rd_en(dec_fifo_rd_en), .ir_fifo_rd_en(ir_fifo_rd_en),
    .fifo_rd_en(w_fifo_rd_en), .fifo_owner(w_fifo_owner),
    .timeout_err(w_timeout_err)
  );

  always @(negedge clk) begin
    if (immed_start) n_starts++;
    if (done)        n_dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_count = '0; req_8bit = '0;
    immed_complete = 1'b0; immediate = '0;
    dec_fifo_rd_en = 1'b0; ir_fifo_rd_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({immed1, immed2} !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_immeds: got %h want 0", {immed1, immed2});
    end
    n_checks++;
    if ({done, immed_start, immed_is_8bit, fifo_owner, timeout_err} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {done, immed_start, immed_is_8bit, fifo_owner, timeout_err});
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_count0();
    int s0 = n_starts;
    req_valid = 1'b1; req_count = 2'd0; req_8bit = 2'b11;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({done, fifo_owner, immed1, immed2} !== {2'b10, 32'h0}) begin
      n_fails++;
      $display("FAIL c0_done: got done=%b own=%b i1=%h i2=%h want 1 0 0 0",
               done, fifo_owner, immed1, immed2);
    end
    tick();
    n_checks++;
    if ({done, req_ready, fifo_owner} !== 3'b010) begin
      n_fails++;
      $display("FAIL c0_after: got done/ready/own=%b want 010",
               {done, req_ready, fifo_owner});
    end
    n_checks++;
    if (n_starts != s0) begin
      n_fails++;
      $display("FAIL c0_starts: got %0d want 0", n_starts - s0);
    end
  endtask

  task automatic test_count1();
    req_valid = 1'b1; req_count = 2'd1; req_8bit = 2'b01;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({immed_start, immed_is_8bit, fifo_owner, req_ready} !== 4'b1110) begin
      n_fails++;
      $display("FAIL c1_start: got start/8b/own/rdy=%b want 1110",
               {immed_start, immed_is_8bit, fifo_owner, req_ready});
    end
    tick();
    n_checks++;
    if ({immed_start, immed_is_8bit, done} !== 3'b010) begin
      n_fails++;
      $display("FAIL c1_wait: got start/8b/done=%b want 010",
               {immed_start, immed_is_8bit, done});
    end
    immed_complete = 1'b1; immediate = 16'hFFF0;
    tick();
    immed_complete = 1'b0; immediate = 16'h0;
    n_checks++;
    if ({done, immed1, immed2} !== {1'b1, 16'hFFF0, 16'h0}) begin
      n_fails++;
      $display("FAIL c1_done: got done=%b i1=%h i2=%h want 1 fff0 0000",
               done, immed1, immed2);
    end
    tick();
    n_checks++;
    if ({done, immed1} !== {1'b0, 16'hFFF0}) begin
      n_fails++;
      $display("FAIL c1_hold: got done=%b i1=%h want 0 fff0", done, immed1);
    end
  endtask

  task automatic test_count2_arb();
    int s0 = n_starts;
    int d0 = n_dones;
    dec_fifo_rd_en = 1'b1;
    #1;
    n_checks++;
    if ({fifo_rd_en, fifo_owner} !== 2'b10) begin
      n_fails++;
      $display("FAIL arb_idle: got rd/own=%b want 10", {fifo_rd_en, fifo_owner});
    end
    dec_fifo_rd_en = 1'b0;
    req_valid = 1'b1; req_count = 2'd2; req_8bit = 2'b01;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({immed_start, immed_is_8bit} !== 2'b11) begin
      n_fails++;
      $display("FAIL c2_start1: got start/8b=%b want 11", {immed_start, immed_is_8bit});
    end
    tick();
    dec_fifo_rd_en = 1'b1; ir_fifo_rd_en = 1'b0;
    #1;
    n_checks++;
    if ({fifo_rd_en, fifo_owner} !== 2'b01) begin
      n_fails++;
      $display("FAIL arb_wait_dec: got rd/own=%b want 01", {fifo_rd_en, fifo_owner});
    end
    dec_fifo_rd_en = 1'b0; ir_fifo_rd_en = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fails++;
      $display("FAIL arb_wait_ir: got %b want 1", fifo_rd_en);
    end
    ir_fifo_rd_en = 1'b0;
    immed_complete = 1'b1; immediate = 16'h0012;
    tick();
    immed_complete = 1'b0;
    n_checks++;
    if ({immed_start, immed_is_8bit, done, immed1} !== {3'b100, 16'h0012}) begin
      n_fails++;
      $display("FAIL c2_start2: got start/8b/done=%b i1=%h want 100 0012",
               {immed_start, immed_is_8bit, done}, immed1);
    end
    tick();
    immed_complete = 1'b1; immediate = 16'hBEEF;
    tick();
    immed_complete = 1'b0; immediate = 16'h0;
    n_checks++;
    if ({done, immed1, immed2} !== {1'b1, 16'h0012, 16'hBEEF}) begin
      n_fails++;
      $display("FAIL c2_done: got done=%b i1=%h i2=%h want 1 0012 beef",
               done, immed1, immed2);
    end
    tick();
    n_checks++;
    if ((n_starts - s0) != 2 || (n_dones - d0) != 1) begin
      n_fails++;
      $display("FAIL c2_counts: got starts=%0d dones=%0d want 2 1",
               n_starts - s0, n_dones - d0);
    end
  endtask

  task automatic test_flush();
    int d0 = n_dones;
    req_valid = 1'b1; req_count = 2'd2; req_8bit = 2'b00;
    tick();
    req_valid = 1'b0;
    tick();
    immed_complete = 1'b1; immediate = 16'h1234; flush = 1'b1;
    tick();
    immed_complete = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if ({done, fifo_owner, req_ready, immed1} !== {3'b001, 16'h0}) begin
      n_fails++;
      $display("FAIL flush_idle: got done/own/rdy=%b i1=%h want 001 0000",
               {done, fifo_owner, req_ready}, immed1);
    end
    tick();
    n_checks++;
    if (n_dones != d0 || req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL flush_nodone: got dones=%0d rdy=%b want 0 1",
               n_dones - d0, req_ready);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    req_valid = 1'b1; req_count = 2'd1; req_8bit = 2'b00;
    tick();
    req_valid = 1'b0;
    tick();
    tick(); tick(); tick();
    n_checks++;
    if ({w_timeout_err, w_fifo_owner} !== 2'b01) begin
      n_fails++;
      $display("FAIL wd_early: got err/own=%b want 01", {w_timeout_err, w_fifo_owner});
    end
    tick();
    n_checks++;
    if ({w_timeout_err, w_fifo_owner, w_req_ready, w_done} !== 4'b1010) begin
      n_fails++;
      $display("FAIL wd_expire: got err/own/rdy/done=%b want 1010",
               {w_timeout_err, w_fifo_owner, w_req_ready, w_done});
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b1; req_count = 2'd1; req_8bit = 2'b00;
    tick();
    req_valid = 1'b0;
    tick();
    immed_complete = 1'b1; immediate = 16'h00AB;
    tick();
    immed_complete = 1'b0;
    n_checks++;
    if ({w_done, w_timeout_err, w_immed1} !== {2'b11, 16'h00AB}) begin
      n_fails++;
      $display("FAIL wd_later: got done/err=%b i1=%h want 11 00ab",
               {w_done, w_timeout_err}, w_immed1);
    end
    n_checks++;
    if ({done, timeout_err} !== 2'b10) begin
      n_fails++;
      $display("FAIL nowd_err: got done/err=%b want 10", {done, timeout_err});
    end
  endtask

  initial begin
    test_reset();
    test_count0();
    test_count1();
    test_count2_arb();
    test_flush();
    test_watchdog();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
